// File: rtl/hs32_irq_seq.sv
// CPU-side interrupt sequencer: accepts AIC requests at instruction boundaries,
// stacks PC/flags over the data bus, redirects the core, and unwinds on RETI.
module hs32_irq_seq #(
  parameter int unsigned MAX_DEPTH = 4,
  parameter int unsigned DEPTH_W   = 3,
  parameter int unsigned IE_BIT    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               intrq,
  input  logic [4:0]         vec,
  input  logic [31:0]        handler,
  input  logic               nmi,
  input  logic               boundary,
  input  logic               reti,
  input  logic [31:0]        cur_pc,
  input  logic [31:0]        cur_flags,
  input  logic [31:0]        cur_sp,
  output logic               stb,
  input  logic               ack,
  output logic [31:0]        addr,
  output logic [31:0]        dtw,
  input  logic [31:0]        dtr,
  output logic               rw,
  output logic               take,
  output logic [31:0]        new_pc,
  output logic [31:0]        new_flags,
  output logic [31:0]        new_sp,
  output logic               busy,
  output logic [4:0]         cur_vec,
  output logic [DEPTH_W-1:0] depth,
  output logic               reti_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH_PC,
    S_PUSH_FL,
    S_ENTER,
    S_POP_FL,
    S_POP_PC,
    S_LEAVE
  } state_t;

  localparam logic [31:0] IE_MASK = 32'h1 << IE_BIT;

  state_t      state, state_d;
  logic [31:0] pc_q, fl_q, sp_q, hnd_q;
  logic [4:0]  vec_q;
  logic        do_accept, do_pop;
  logic        room;

  assign room = (depth < DEPTH_W'(MAX_DEPTH));
  assign busy = (state != S_IDLE);

  always_comb begin
    state_d   = state;
    stb       = 1'b0;
    rw        = 1'b0;
    addr      = '0;
    dtw       = '0;
    take      = 1'b0;
    reti_err  = 1'b0;
    do_accept = 1'b0;
    do_pop    = 1'b0;
    unique case (state)
      S_IDLE: begin
        // A legal RETI wins over a new request; a RETI at depth 0 only flags an error
        do_pop    = reti && (depth != '0);
        reti_err  = reti && (depth == '0);
        do_accept = !do_pop && boundary && intrq && (nmi || cur_flags[IE_BIT]) && room;
        if (do_pop)         state_d = S_POP_FL;
        else if (do_accept) state_d = S_PUSH_PC;
      end
      S_PUSH_PC: begin
        stb  = 1'b1;
        rw   = 1'b1;
        addr = sp_q - 32'd4;
        dtw  = pc_q;
        if (ack) state_d = S_PUSH_FL;
      end
      S_PUSH_FL: begin
        stb  = 1'b1;
        rw   = 1'b1;
        addr = sp_q - 32'd8;
        dtw  = fl_q;
        if (ack) state_d = S_ENTER;
      end
      S_POP_FL: begin
        stb  = 1'b1;
        addr = sp_q;
        if (ack) state_d = S_POP_PC;
      end
      S_POP_PC: begin
        stb  = 1'b1;
        addr = sp_q + 32'd4;
        if (ack) state_d = S_LEAVE;
      end
      S_ENTER, S_LEAVE: begin
        take    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      fl_q      <= '0;
      sp_q      <= '0;
      hnd_q     <= '0;
      vec_q     <= '0;
      new_pc    <= '0;
      new_flags <= '0;
      new_sp    <= '0;
      depth     <= '0;
      cur_vec   <= '0;
    end else begin
      if (do_accept) begin
        pc_q  <= cur_pc;
        fl_q  <= cur_flags;
        sp_q  <= cur_sp & ~32'h3;
        hnd_q <= handler;
        vec_q <= vec;
      end
      if (do_pop) sp_q <= cur_sp & ~32'h3;
      // new_* are loaded on the last bus ack so they are valid for the whole take cycle
      unique case (state)
        S_PUSH_FL: if (ack) begin
          new_pc    <= hnd_q & ~32'h3;
          new_sp    <= sp_q - 32'd8;
          new_flags <= fl_q & ~IE_MASK;
        end
        S_ENTER: begin
          depth   <= depth + DEPTH_W'(1);
          cur_vec <= vec_q;
        end
        S_POP_FL: if (ack) fl_q <= dtr;
        S_POP_PC: if (ack) begin
          new_pc    <= dtr & ~32'h3;
          new_flags <= fl_q;
          new_sp    <= sp_q + 32'd8;
        end
        S_LEAVE: depth <= depth - DEPTH_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hs32_irq_seq.sv
// Self-checking bench for hs32_irq_seq: vector table plus hand sequences,
// with bus transfers and takes checked against scoreboard queues.
module tb_hs32_irq_seq;

  localparam int MAX_DEPTH = 4;
  localparam int DEPTH_W   = 3;
  localparam int IE_BIT    = 5;
  localparam logic [31:0] IE_MASK = 32'h1 << IE_BIT;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               intrq = 1'b0;
  logic [4:0]         vec = '0;
  logic [31:0]        handler = '0;
  logic               nmi = 1'b0;
  logic               boundary = 1'b1;
  logic               reti = 1'b0;
  logic [31:0]        cur_pc = '0;
  logic [31:0]        cur_flags = '0;
  logic [31:0]        cur_sp = '0;
  logic               stb;
  logic               ack = 1'b0;
  logic [31:0]        addr;
  logic [31:0]        dtw;
  logic [31:0]        dtr = '0;
  logic               rw;
  logic               take;
  logic [31:0]        new_pc;
  logic [31:0]        new_flags;
  logic [31:0]        new_sp;
  logic               busy;
  logic [4:0]         cur_vec;
  logic [DEPTH_W-1:0] depth;
  logic               reti_err;

  hs32_irq_seq #(
    .MAX_DEPTH(MAX_DEPTH),
    .DEPTH_W  (DEPTH_W),
    .IE_BIT   (IE_BIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .intrq    (intrq),
    .vec      (vec),
    .handler  (handler),
    .nmi      (nmi),
    .boundary (boundary),
    .reti     (reti),
    .cur_pc   (cur_pc),
    .cur_flags(cur_flags),
    .cur_sp   (cur_sp),
    .stb      (stb),
    .ack      (ack),
    .addr     (addr),
    .dtw      (dtw),
    .dtr      (dtr),
    .rw       (rw),
    .take     (take),
    .new_pc   (new_pc),
    .new_flags(new_flags),
    .new_sp   (new_sp),
    .busy     (busy),
    .cur_vec  (cur_vec),
    .depth    (depth),
    .reti_err (reti_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic rw; logic [31:0] addr; logic [31:0] dtw; } bus_t;
  typedef struct { logic [31:0] pc; logic [31:0] fl; logic [31:0] sp; int lat; } take_t;
  typedef struct { logic [31:0] pc; logic [31:0] fl; logic [31:0] sp; } frame_t;
  typedef struct {
    logic [31:0] pc; logic [31:0] fl; logic [31:0] sp; logic [31:0] hnd;
    logic [4:0] v; logic n; logic iq; logic bd; logic acc;
  } vec_t;

  bus_t        bus_q[$];
  take_t       take_q[$];
  frame_t      frames[$];
  logic [31:0] mem [logic [31:0]];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int wait_n = 0;
  int wcnt = 0;
  int exp_depth = 0;
  logic [4:0] exp_vec = '0;
  logic rerr_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic bus_t mk_bus(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus_t b;
    b.rw = w; b.addr = a; b.dtw = d;
    return b;
  endfunction

  function automatic take_t mk_take(input logic [31:0] p, input logic [31:0] f,
                                    input logic [31:0] s, input int l);
    take_t t;
    t.pc = p; t.fl = f; t.sp = s; t.lat = l;
    return t;
  endfunction

  always @(posedge clk) cyc++;

  // Bus slave: ack after wait_n wait cycles, read data from the memory model
  always @(posedge clk) begin
    #2;
    if (stb && wcnt < wait_n) begin
      ack = 1'b0;
      wcnt++;
    end else begin
      ack = stb;
      wcnt = 0;
    end
    dtr = mem.exists(addr) ? mem[addr] : 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (stb) begin
        if (bus_q.size() == 0) bad("bus_unexpected");
        else begin
          chk("bus_rw",   32'(rw), 32'(bus_q[0].rw));
          chk("bus_addr", addr, bus_q[0].addr);
          if (bus_q[0].rw) chk("bus_dtw", dtw, bus_q[0].dtw);
          if (ack) begin
            if (rw) mem[addr] = dtw;
            void'(bus_q.pop_front());
          end
        end
      end
      if (take) begin
        if (take_q.size() == 0) bad("take_unexpected");
        else begin
          take_t t;
          t = take_q.pop_front();
          chk("new_pc",    new_pc,    t.pc);
          chk("new_flags", new_flags, t.fl);
          chk("new_sp",    new_sp,    t.sp);
          if (t.lat >= 0) chk("take_latency", 32'(cyc - start_cyc), 32'(t.lat));
        end
      end
      if (reti_err && !rerr_ok) bad("reti_err_unexpected");
    end
  end

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((bus_q.size() != 0 || take_q.size() != 0 || busy) && n < maxc) begin
      @(negedge clk); #1;
      n++;
      if (take_q.size() == 0) intrq = 1'b0;
    end
    if (n >= maxc) bad("drain_timeout");
  endtask

  task automatic request(input logic [31:0] pc, input logic [31:0] fl, input logic [31:0] sp,
                         input logic [31:0] hnd, input logic [4:0] v, input logic n,
                         input logic iq, input logic bd, input logic acc, input int lat);
    logic [31:0] spa;
    frame_t f;
    spa = sp & ~32'h3;
    if (acc) begin
      bus_q.push_back(mk_bus(1'b1, spa - 32'd4, pc));
      bus_q.push_back(mk_bus(1'b1, spa - 32'd8, fl));
      take_q.push_back(mk_take(hnd & ~32'h3, fl & ~IE_MASK, spa - 32'd8, lat));
      f.pc = pc; f.fl = fl; f.sp = spa - 32'd8;
      frames.push_back(f);
      exp_depth++;
      exp_vec = v;
    end
    cur_pc = pc; cur_flags = fl; cur_sp = sp; handler = hnd; vec = v;
    nmi = n; intrq = iq; boundary = bd;
    start_cyc = cyc;
    @(posedge clk); #1;
    intrq = 1'b0; nmi = 1'b0; boundary = 1'b1;
    chk("busy_after_req", 32'(busy), 32'(acc));
    if (acc) drain(60);
    else chk("no_stb", 32'(stb), 32'h0);
    chk("depth", 32'(depth), 32'(exp_depth));
    chk("cur_vec", 32'(cur_vec), 32'(exp_vec));
  endtask

  task automatic do_reti(input int wn, input int lat);
    frame_t f;
    f = frames.pop_back();
    bus_q.push_back(mk_bus(1'b0, f.sp, 32'h0));
    bus_q.push_back(mk_bus(1'b0, f.sp + 32'd4, 32'h0));
    take_q.push_back(mk_take(f.pc & ~32'h3, f.fl, f.sp + 32'd8, lat));
    exp_depth--;
    wait_n = wn;
    cur_sp = f.sp;
    reti = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    reti = 1'b0;
    chk("busy_after_reti", 32'(busy), 32'h1);
    drain(60);
    chk("depth_after_reti", 32'(depth), 32'(exp_depth));
    wait_n = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  vec_t tbl[7];

  initial begin
    tbl[0] = '{32'h200,  32'h20,       32'h1000, 32'h403,      5'd3,  1'b0, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{32'h200,  32'h00,       32'h1000, 32'h403,      5'd3,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{32'h200,  32'h00,       32'h1000, 32'h403,      5'd0,  1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{32'h1235, 32'hFFFFFFFF, 32'h0,    32'hFFFFFFFF, 5'd31, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{32'h400,  32'h21,       32'h1003, 32'h80,       5'd5,  1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{32'h200,  32'h20,       32'h1000, 32'h403,      5'd3,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{32'h200,  32'h20,       32'h1000, 32'h403,      5'd3,  1'b1, 1'b1, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_stb",   32'(stb),  32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_take",  32'(take), 32'h0);
    chk("rst_rw",    32'(rw),   32'h0);
    chk("rst_addr",  addr,      32'h0);
    chk("rst_dtw",   dtw,       32'h0);
    chk("rst_newpc", new_pc,    32'h0);
    chk("rst_newfl", new_flags, 32'h0);
    chk("rst_newsp", new_sp,    32'h0);
    chk("rst_depth", 32'(depth), 32'h0);
    chk("rst_vec",   32'(cur_vec), 32'h0);
    chk("rst_err",   32'(reti_err), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      request(tbl[i].pc, tbl[i].fl, tbl[i].sp, tbl[i].hnd, tbl[i].v,
              tbl[i].n, tbl[i].iq, tbl[i].bd, tbl[i].acc, 3);
      if (tbl[i].acc) do_reti(0, 3);
    end

    // Two wait states on every transfer
    wait_n = 2;
    request(32'h200, 32'h20, 32'h1000, 32'h403, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 7);
    do_reti(2, 7);

    // RETI at depth 0
    rerr_ok = 1'b1;
    reti = 1'b1;
    @(posedge clk); #1;
    chk("reti_err_pulse", 32'(reti_err), 32'h1);
    chk("reti_err_busy",  32'(busy),     32'h0);
    reti = 1'b0;
    @(posedge clk); #1;
    chk("reti_err_clear", 32'(reti_err), 32'h0);
    chk("reti_err_nostb", 32'(stb),      32'h0);
    chk("reti_err_idle",  32'(busy),     32'h0);
    rerr_ok = 1'b0;

    // RETI and a held request together at depth 1: pop first, then re-entry
    request(32'h200, 32'h20, 32'h1000, 32'h403, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 3);
    begin
      frame_t f, g;
      f = frames.pop_back();
      bus_q.push_back(mk_bus(1'b0, f.sp, 32'h0));
      bus_q.push_back(mk_bus(1'b0, f.sp + 32'd4, 32'h0));
      take_q.push_back(mk_take(f.pc & ~32'h3, f.fl, f.sp + 32'd8, 3));
      bus_q.push_back(mk_bus(1'b1, 32'hFFC, 32'h300));
      bus_q.push_back(mk_bus(1'b1, 32'hFF8, 32'h20));
      take_q.push_back(mk_take(32'h500, 32'h00, 32'hFF8, -1));
      g.pc = 32'h300; g.fl = 32'h20; g.sp = 32'hFF8;
      frames.push_back(g);
      exp_vec = 5'd7;
      cur_sp = f.sp; cur_pc = 32'h300; cur_flags = 32'h20; vec = 5'd7; handler = 32'h500;
      reti = 1'b1; intrq = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      reti = 1'b0;
      cur_sp = 32'h1000;
      drain(60);
      chk("both_depth", 32'(depth), 32'h1);
      chk("both_vec", 32'(cur_vec), 32'h7);
    end
    do_reti(0, 3);

    // Fill to MAX_DEPTH, then an NMI must be refused
    for (int i = 0; i < MAX_DEPTH; i++)
      request(32'h100 + 32'(i * 16), 32'h20 | 32'(i), 32'h2000 - 32'(i * 8),
              32'h600 + 32'(i * 4), 5'(i + 1), 1'b0, 1'b1, 1'b1, 1'b1, 3);
    request(32'h900, 32'h20, 32'h2000 - 32'(MAX_DEPTH * 8), 32'h700, 5'd0,
            1'b1, 1'b1, 1'b1, 1'b0, 3);
    intrq = 1'b1; nmi = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("full_busy", 32'(busy), 32'h0);
    end
    intrq = 1'b0; nmi = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++) do_reti(0, 3);

    // Asynchronous reset while PUSH_FL is waiting for ack
    request(32'h200, 32'h20, 32'h1000, 32'h403, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 3);
    begin
      int n;
      wait_n = 2;
      bus_q.push_back(mk_bus(1'b1, 32'hFF4, 32'h700));
      bus_q.push_back(mk_bus(1'b1, 32'hFF0, 32'h20));
      cur_pc = 32'h700; cur_flags = 32'h20; cur_sp = 32'hFF8; vec = 5'd9; handler = 32'h900;
      intrq = 1'b1;
      @(posedge clk); #1;
      intrq = 1'b0;
      n = 0;
      while (!(stb && addr == 32'hFF0) && n < 20) begin
        @(negedge clk); #1;
        n++;
      end
      if (n >= 20) bad("push_fl_timeout");
      reset = 1'b1;
      #1;
      chk("arst_stb",   32'(stb),   32'h0);
      chk("arst_busy",  32'(busy),  32'h0);
      chk("arst_depth", 32'(depth), 32'h0);
      chk("arst_take",  32'(take),  32'h0);
      bus_q.delete();
      take_q.delete();
      frames.delete();
      exp_depth = 0;
      exp_vec = '0;
      wait_n = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("arst_vec", 32'(cur_vec), 32'h0);
    end
    request(32'h240, 32'h20, 32'h3000, 32'h404, 5'd4, 1'b0, 1'b1, 1'b1, 1'b1, 3);
    do_reti(0, 3);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hs32_irq_seq.md
Name: hs32_irq_seq

Overview:
- CPU-side interrupt sequencer; the consumer end of the AIC request interface (intrq/vec/handler/nmi).
- At an instruction boundary it accepts a request, pushes PC and flags to the stack as a bus master, then redirects the core to the ISR.
- On RETI it pops the context and restores it.
- Sits between the AIC outputs, the core's fetch/flags/SP state and the data-memory bus.

Parameters:
- MAX_DEPTH, 4: maximum interrupt nesting depth.
- DEPTH_W, 3: width of depth counter; must hold MAX_DEPTH.
- IE_BIT, 5: bit index of the interrupt-enable flag in the flags word.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- intrq  in  1  interrupt request from the AIC
- vec  in  5  interrupt vector from the AIC
- handler  in  32  ISR address from the AIC (word aligned)
- nmi  in  1  non-maskable request from the AIC
- boundary  in  1  core is at an instruction boundary and may be redirected
- reti  in  1  one-cycle pulse: core executed RETI
- cur_pc  in  32  PC of the next instruction to execute
- cur_flags  in  32  current flags word
- cur_sp  in  32  current stack pointer
- stb  out  1  bus strobe
- ack  in  1  bus acknowledge
- addr  out  32  bus byte address
- dtw  out  32  write data
- dtr  in  32  read data
- rw  out  1  1 = write, 0 = read
- take  out  1  one-cycle pulse: core loads new_pc/new_flags/new_sp
- new_pc  out  32  PC to load
- new_flags  out  32  flags to load
- new_sp  out  32  SP to load
- busy  out  1  sequencer is not IDLE; core must stall
- cur_vec  out  5  vector of the most recent accepted entry
- depth  out  DEPTH_W  current nesting depth
- reti_err  out  1  one-cycle pulse: RETI issued at depth 0

Behaviour:
- Reset (async, any state): state=IDLE. stb, rw, take, busy, reti_err=0. addr, dtw, new_* =0. cur_vec=0, depth=0.
- States: IDLE, PUSH_PC, PUSH_FL, ENTER, POP_FL, POP_PC, LEAVE. busy=1 in every state except IDLE.
- Accept condition in IDLE: boundary & intrq & (nmi | cur_flags[IE_BIT]) & (depth<MAX_DEPTH).
  - On accept, latch vec, handler, cur_pc, cur_flags, and sp=cur_sp&~3.
  - Go to PUSH_PC.
- reti vs. accept in IDLE:
  - reti & depth>0 takes priority over accept; latch sp=cur_sp&~3 and go to POP_FL.
  - reti & depth==0 pulses reti_err for one cycle, stays IDLE; a simultaneous accept proceeds normally.
- Bus handshake:
  - On entering a bus state, drive stb=1 with addr/dtw/rw; hold all of them stable until a cycle with ack=1.
  - The transaction completes in that cycle; read data is sampled from dtr in that same cycle.
  - ack=1 combinationally (zero wait) gives one cycle per transfer.
  - stb=0 in every non-bus state.
- PUSH_PC: addr=sp-4, dtw=saved pc, rw=1. On ack go to PUSH_FL.
- PUSH_FL: addr=sp-8, dtw=saved flags, rw=1. On ack go to ENTER.
- ENTER (one cycle): take=1, then go to IDLE.
  - new_pc = handler&~3.
  - new_sp = sp-8.
  - new_flags = saved flags with IE_BIT cleared.
  - depth+=1; cur_vec = latched vec.
- POP_FL: addr=sp, rw=0. On ack latch flags=dtr and go to POP_PC.
- POP_PC: addr=sp+4, rw=0. On ack latch pc=dtr&~3 and go to LEAVE.
- LEAVE (one cycle): take=1, then go to IDLE.
  - new_pc = popped pc; new_flags = popped flags; new_sp = sp+8.
  - depth-=1.
- take is high only in ENTER/LEAVE. new_* hold their value until the next take.
- Arithmetic is 32-bit, wrap-around: sp=0 pushes to 0xFFFFFFFC/0xFFFFFFF8; sp=0xFFFFFFF8 pops to new_sp=0.
- Inputs intrq/vec/handler/reti are ignored while busy; requests must remain asserted to be taken later.
- At depth==MAX_DEPTH, no request is accepted, NMI included.
- Minimum entry latency with zero-wait ack: accept→take = 3 cycles (PUSH_PC, PUSH_FL, ENTER).
- Minimum RETI latency: 3 cycles (POP_FL, POP_PC, LEAVE).

Test Plan:
- Entry:
  - Stimulus: IE=1, ack=1, sp=0x1000, pc=0x200, flags=0x20, intrq=1, vec=3, handler=0x403, boundary=1.
  - Required: writes 0x200@0xFFC, then 0x20@0xFF8; take on 3rd cycle; new_pc=0x400, new_sp=0xFF8, new_flags=0x00; depth=1; cur_vec=3.
- Wait states:
  - Stimulus: same as entry, with ack low for 2 cycles on each write.
  - Required: stb/addr/dtw stable through the wait cycles; take on 7th cycle; same results.
- Masking:
  - Stimulus: IE=0 with intrq=1, nmi=0.
  - Required: no stb, busy=0.
  - Stimulus: repeat with nmi=1, vec=0.
  - Required: entry proceeds.
- RETI:
  - Stimulus: after entry, reti at sp=0xFF8; memory returns 0x20@0xFF8 and 0x200@0xFFC.
  - Required: two reads; take with new_pc=0x200, new_flags=0x20, new_sp=0x1000; depth=0.
- Corner cases:
  - Stimulus: reti at depth=0.
  - Required: reti_err pulse, no bus cycle.
  - Stimulus: reti and intrq in the same cycle at depth=1.
  - Required: the pop sequence runs first.
  - Stimulus: depth=MAX_DEPTH with nmi=1.
  - Required: ignored.
- Reset mid-sequence:
  - Stimulus: assert reset during PUSH_FL with stb=1.
  - Required: stb=0, busy=0, depth=0 immediately (asynchronous); the next accepted request restarts at PUSH_PC.
